nibble_ram_arbiter: RTL and testbench
=====================================

NIBBLE_RAM_ARBITER -- requirements
Module: nibble_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, the RAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, the maximum consecutive accesses per grant while the other port is requesting; legal range 1..15.
REQ-004 SHALL have port clk  in  1  system clock, rising-edge active.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W: CPU access request, write enable, address and write data.
REQ-007 SHALL have ports cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out DATA_W: CPU grant, read-return strobe and read data.
REQ-008 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, identical to the cpu_* ports, for the debug/loader host.
REQ-009 SHALL have ports mem_cs out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: the single-port RAM interface.
REQ-010 SHALL have port owner  out  2  current owner: 00 none, 01 CPU, 10 DBG.

Function
REQ-011 SHALL implement an FSM with states IDLE, CPU and DBG; owner and the gnt outputs SHALL be decoded from the registered state only.
REQ-012 IDLE: if exactly one port requests, the FSM SHALL go to that port's state on the next edge; if both request, it SHALL go to the port that is not last_owner.
REQ-013 last_owner SHALL update to the granted port on every transition into CPU or DBG.
REQ-014 In CPU/DBG, an access SHALL occur in every cycle where gnt=1 and that port's req=1; mem_cs=req, and mem_we/mem_addr/mem_wdata SHALL be combinationally muxed from the owner's port.
REQ-015 In IDLE, mem_cs and mem_we SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-016 A 4-bit burst counter SHALL count accesses; it SHALL clear on every state change.
REQ-017 When the owner's req drops: go to the other state if the other port requests, else go to IDLE.
REQ-018 When the counter reaches MAX_BURST and the other port requests, the FSM SHALL switch directly to the other state with no IDLE cycle.
REQ-019 When the counter reaches MAX_BURST and the other port is not requesting, the FSM SHALL keep the grant and clear the counter.
REQ-020 The access in the cycle before a switch SHALL complete normally; grants SHALL never overlap, and no cycle SHALL have both gnt outputs high.
REQ-021 A read access (cs=1, we=0) in cycle N SHALL register mem_rdata into the owner's rdata and pulse that port's rvalid for exactly one cycle at N+1.
REQ-022 rdata SHALL hold its last value between reads; writes SHALL produce no rvalid.
REQ-023 Latency from req rising in IDLE to first access SHALL be 1 cycle; read data SHALL return 2 cycles after req rises.
REQ-024 A port SHALL keep req, we, addr and wdata stable until it samples gnt=1; the arbiter SHALL not buffer requests.

Reset
REQ-025 Asserting reset SHALL immediately force: state IDLE, last_owner DBG (so the CPU wins the first tie), counter 0, all gnt/rvalid 0, all rdata 0, owner 00, and mem_* outputs 0.
REQ-026 Reset mid-burst SHALL abort the current grant within the same cycle and drop mem_cs asynchronously; no rvalid SHALL follow the aborted access.
REQ-027 After reset deasserts, arbitration SHALL resume from IDLE on the first rising clk edge.

Structure
REQ-028 The package nibble_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state encoding and the owner encoding (NONE, CPU, DBG).
REQ-029 The port-to-memory mux and the read-return register SHALL be one sub-module, arb_port_mux, instantiated once; the FSM and counter stay in nibble_ram_arbiter.

Verification
REQ-030 CPU-only read: cpu_req=1, we=0, addr=0x123, RAM[0x123]=0xA -> cpu_gnt at +1, mem_cs=1/mem_addr=0x123 at +1, cpu_rvalid=1 and cpu_rdata=0xA at +2.
REQ-031 Tie after reset: both ports request a read in the same cycle -> CPU is granted first; on the next tie from IDLE, DBG is granted first.
REQ-032 Burst fairness: MAX_BURST=4, CPU holds req, DBG requests at CPU's first access -> exactly 4 CPU accesses, then dbg_gnt=1 in the next cycle with no IDLE cycle and no overlap.
REQ-033 Uncontended burst: CPU performs 10 writes of 0x5 to 0x000..0x009, DBG idle -> cpu_gnt stays high for all 10 cycles; readback of all 10 addresses returns 0x5.
REQ-034 Reset mid-burst: reset during the 2nd of 3 DBG reads -> dbg_gnt and mem_cs drop the same cycle, no dbg_rvalid follows, owner=00.
REQ-035 Owner drop: DBG writes 0x7 to 0xFFF and drops req while CPU requests -> next cycle cpu_gnt=1, dbg_gnt=0; a CPU read of 0xFFF returns 0x7.

Source files
------------

// File: rtl/nibble_ram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_pkg : shared widths, FSM state and owner encodings             |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package nibble_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 4;
   localparam int BURST_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CPU  = 2'b01,
      ST_DBG  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DBG  = 2'b10
   } owner_t;

endpackage
`default_nettype wire

// File: rtl/nibble_ram_arbiter_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_port_mux : owner-steered RAM mux and per-port read-return regs    |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module arb_port_mux
   import nibble_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  owner_t            owner,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic rd_cpu;
   logic rd_dbg;

   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (owner)
         OWN_CPU: begin
            mem_cs    = cpu_req;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         OWN_DBG: begin
            mem_cs    = dbg_req;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   assign rd_cpu = mem_cs && !mem_we && (owner == OWN_CPU);
   assign rd_dbg = mem_cs && !mem_we && (owner == OWN_DBG);

   // Async reset clears the strobes, so an aborted read never returns.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
      end else begin
         cpu_rvalid <= rd_cpu;
         dbg_rvalid <= rd_dbg;
         if (rd_cpu) cpu_rdata <= mem_rdata;
         if (rd_dbg) dbg_rdata <= mem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/nibble_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_ram_arbiter : CPU/debug arbiter for a single-port RAM         |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module nibble_ram_arbiter
   import nibble_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   state_t             state, state_nxt;
   owner_t             last_owner, last_nxt;
   owner_t             own;
   logic [BURST_W-1:0] burst_cnt, burst_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_owner <= OWN_DBG;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_nxt;
         burst_cnt  <= burst_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last_owner;
      burst_nxt = burst_cnt;
      case (state)
         ST_IDLE: begin
            if (cpu_req && (!dbg_req || last_owner == OWN_DBG)) state_nxt = ST_CPU;
            else if (dbg_req)                                   state_nxt = ST_DBG;
         end
         ST_CPU: begin
            if (!cpu_req) begin
               state_nxt = dbg_req ? ST_DBG : ST_IDLE;
            end else if (burst_cnt == BURST_LAST) begin
               burst_nxt = '0;
               if (dbg_req) state_nxt = ST_DBG;
            end else begin
               burst_nxt = burst_cnt + 1'b1;
            end
         end
         ST_DBG: begin
            if (!dbg_req) begin
               state_nxt = cpu_req ? ST_CPU : ST_IDLE;
            end else if (burst_cnt == BURST_LAST) begin
               burst_nxt = '0;
               if (cpu_req) state_nxt = ST_CPU;
            end else begin
               burst_nxt = burst_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Any state change restarts the burst and records the new grantee.
      if (state_nxt != state) begin
         burst_nxt = '0;
         if (state_nxt == ST_CPU) last_nxt = OWN_CPU;
         if (state_nxt == ST_DBG) last_nxt = OWN_DBG;
      end
   end

   always_comb begin
      own = OWN_NONE;
      case (state)
         ST_CPU:  own = OWN_CPU;
         ST_DBG:  own = OWN_DBG;
         default: own = OWN_NONE;
      endcase
   end

   assign owner   = own;
   assign cpu_gnt = (state == ST_CPU);
   assign dbg_gnt = (state == ST_DBG);

   arb_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_port_mux (
      .clk        (clk),
      .reset      (reset),
      .owner      (own),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_nibble_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nibble_ram_arbiter : directed self-checking bench with RAM model  |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_nibble_ram_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [11:0] cpu_addr;
   logic [3:0]  cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [11:0] dbg_addr;
   logic [3:0]  dbg_wdata, dbg_rdata;
   logic        mem_cs, mem_we;
   logic [11:0] mem_addr;
   logic [3:0]  mem_wdata, mem_rdata;
   logic [1:0]  owner;

   logic [3:0]  ram [0:4095];

   int tests;
   int failed;

   nibble_ram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .owner      (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Asynchronous-read RAM; contents reloaded while reset is held.
   assign mem_rdata = mem_cs ? ram[mem_addr] : 4'h0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 4'h0;
         ram[12'h123] <= 4'hA;
         ram[12'h456] <= 4'h3;
      end else if (mem_cs && mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int  n_acc;
   int  n_ok;
   logic overlap;
   logic idle_seen;
   logic any_rvalid;

   initial begin
      tests = 0; failed = 0;
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      step(); step();
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_owner", owner, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
      chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      reset = 1'b0;

      // Tie right after reset: CPU first, then DBG takes over when CPU drops.
      step();
      cpu_req = 1; cpu_addr = 12'h123; dbg_req = 1; dbg_addr = 12'h456; #1;
      step();
      chk("tie1_cpu_gnt", cpu_gnt, 1);
      chk("tie1_dbg_gnt", dbg_gnt, 0);
      chk("tie1_owner", owner, 1);
      chk("tie1_mem_addr", mem_addr, 12'h123);
      step();
      cpu_req = 0; #1;
      chk("tie1_cpu_rvalid", cpu_rvalid, 1);
      chk("tie1_cpu_rdata", cpu_rdata, 4'hA);
      step();
      chk("tie1_dbg_gnt2", {cpu_gnt, dbg_gnt}, 2'b01);
      chk("tie1_dbg_addr", mem_addr, 12'h456);
      step();
      dbg_req = 0; #1;
      chk("tie1_dbg_rvalid", dbg_rvalid, 1);
      chk("tie1_dbg_rdata", dbg_rdata, 4'h3);
      step();
      chk("tie1_idle_owner", owner, 0);

      // CPU-only read of 0x123.
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123; #1;
      chk("rd_pre_gnt", cpu_gnt, 0);
      chk("rd_pre_cs", mem_cs, 0);
      step();
      chk("rd_gnt", cpu_gnt, 1);
      chk("rd_cs", mem_cs, 1);
      chk("rd_addr", mem_addr, 12'h123);
      step();
      cpu_req = 0; #1;
      chk("rd_rvalid", cpu_rvalid, 1);
      chk("rd_rdata", cpu_rdata, 4'hA);
      step();
      chk("rd_rvalid_pulse", cpu_rvalid, 0);
      chk("rd_rdata_hold", cpu_rdata, 4'hA);
      chk("rd_idle", {owner, cpu_gnt}, 0);

      // Second tie: CPU was last owner, so DBG wins.
      cpu_req = 1; dbg_req = 1; #1;
      step();
      chk("tie2_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
      chk("tie2_owner", owner, 2);
      step();
      dbg_req = 0; #1;
      chk("tie2_dbg_rdata", {dbg_rvalid, dbg_rdata}, 5'h13);
      step();
      chk("tie2_cpu_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
      step();
      cpu_req = 0; #1;
      chk("tie2_cpu_rvalid", cpu_rvalid, 1);
      step();

      // Burst fairness: DBG requests at CPU's first access.
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123; #1;
      step();
      dbg_req = 1; dbg_we = 0; dbg_addr = 12'h456; #1;
      n_acc = 0; overlap = 0; idle_seen = 0;
      for (int i = 0; i < 20 && !dbg_gnt; i++) begin
         if (cpu_gnt && mem_cs) n_acc++;
         if (cpu_gnt && dbg_gnt) overlap = 1;
         if (owner == 2'b00) idle_seen = 1;
         step();
      end
      chk("burst_cpu_accesses", n_acc, 4);
      chk("burst_dbg_gnt", dbg_gnt, 1);
      chk("burst_cpu_gnt_off", cpu_gnt, 0);
      chk("burst_no_overlap", overlap, 0);
      chk("burst_no_idle", idle_seen, 0);
      cpu_req = 0; #1;
      chk("burst_last_cpu_read", {cpu_rvalid, cpu_rdata}, 5'h1A);
      step();
      dbg_req = 0; #1;
      chk("burst_dbg_read", {dbg_rvalid, dbg_rdata}, 5'h13);
      step();

      // Uncontended 10-write burst, then readback.
      cpu_req = 1; cpu_we = 1; cpu_addr = 12'h000; cpu_wdata = 4'h5; #1;
      step();
      n_acc = 0; any_rvalid = 0;
      for (int i = 0; i < 10; i++) begin
         cpu_addr = 12'(i); #1;
         if (cpu_gnt && !dbg_gnt && mem_cs && mem_we && mem_addr == 12'(i)) n_acc++;
         if (cpu_rvalid) any_rvalid = 1;
         step();
      end
      if (cpu_rvalid) any_rvalid = 1;
      cpu_req = 0; cpu_we = 0; #1;
      chk("wr_gnt_cycles", n_acc, 10);
      chk("wr_no_rvalid", any_rvalid, 0);
      step();
      cpu_req = 1; cpu_addr = 12'h000; #1;
      step();
      n_ok = 0;
      for (int i = 0; i < 10; i++) begin
         cpu_addr = 12'(i); #1;
         step();
         if (cpu_rvalid && cpu_rdata == 4'h5) n_ok++;
      end
      cpu_req = 0; #1;
      chk("wr_readback", n_ok, 10);
      step();

      // DBG writes 0xFFF then drops req while CPU waits.
      dbg_req = 1; dbg_we = 1; dbg_addr = 12'hFFF; dbg_wdata = 4'h7; #1;
      step();
      chk("drop_dbg_gnt", dbg_gnt, 1);
      chk("drop_mem_we", {mem_cs, mem_we}, 2'b11);
      chk("drop_mem_wdata", mem_wdata, 4'h7);
      chk("drop_mem_addr", mem_addr, 12'hFFF);
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'hFFF;
      step();
      dbg_req = 0; dbg_we = 0; #1;
      chk("drop_gap_cs", {dbg_gnt, mem_cs}, 2'b10);
      step();
      chk("drop_cpu_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
      chk("drop_cpu_we", mem_we, 0);
      step();
      cpu_req = 0; #1;
      chk("drop_readback", {cpu_rvalid, cpu_rdata}, 5'h17);
      step();

      // Reset during the second of three DBG reads.
      dbg_req = 1; dbg_we = 0; dbg_addr = 12'h456; #1;
      step();
      step();
      dbg_addr = 12'h457; #1;
      chk("rmid_pre", {dbg_gnt, mem_cs, dbg_rvalid}, 3'b111);
      reset = 1; #1;
      chk("rmid_gnt", dbg_gnt, 0);
      chk("rmid_cs", mem_cs, 0);
      chk("rmid_owner", owner, 0);
      chk("rmid_rvalid", dbg_rvalid, 0);
      dbg_req = 0;
      step();
      chk("rmid_rvalid_edge", dbg_rvalid, 0);
      reset = 0;
      step();
      chk("rmid_after", {dbg_rvalid, dbg_gnt, owner}, 0);
      chk("rmid_rdata", dbg_rdata, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
